// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, instruction-memory request, IF/ID register and a one-entry skid
// buffer that absorbs the word returned in the cycle a stall arrives.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [5:0]  opcode
);

    localparam logic [1:0] FETCH    = 2'd0;
    localparam logic [1:0] HOLD     = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;

    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;

    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    // Wraps modulo 2^32; the low two bits stay zero because every PC source is aligned.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (branch_taken) begin
            // Flush wins over stall and drops any word returned this cycle.
            state_d      = REDIRECT;
            pc_d         = branch_target & ALIGN_MASK;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_valid_d = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_plus4;
                        if (stall) begin
                            skid_valid_d = 1'b1;
                            skid_instr_d = imem_rdata;
                            skid_pc4_d   = pc_plus4;
                            state_d      = HOLD;
                        end else begin
                            ifid_valid_d = 1'b1;
                            ifid_instr_d = imem_rdata;
                            ifid_pc4_d   = pc_plus4;
                        end
                    end else if (!stall) begin
                        // Bubble; pc4 keeps its last value.
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = skid_instr_q;
                        ifid_pc4_d   = skid_pc4_q;
                        skid_valid_d = 1'b0;
                        state_d      = FETCH;
                    end
                end
                REDIRECT: begin
                    state_d = FETCH;
                end
                default: begin
                    state_d = REDIRECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= REDIRECT;
            pc_q         <= RESET_PC & ALIGN_MASK;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc4_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign imem_req    = reset && (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign if_id_valid = ifid_valid_q;
    assign if_id_instr = ifid_instr_q;
    assign if_id_pc4   = ifid_pc4_q;
    assign opcode      = ifid_instr_q[31:26];

    // HOLD is only ever entered with a buffered word and left when it drains.
    assert property (@(posedge clk) disable iff (!reset) (state_q == HOLD) |-> skid_valid_q);
    assert property (@(posedge clk) disable iff (!reset) pc_q[1:0] == 2'b00);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios followed by random traffic, with a scoreboard
// of accepted fetches consumed whenever IF/ID is valid and not held or flushed.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  opcode;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_instr[$];
    logic [31:0] exp_pc4[$];
    logic [31:0] next_addr;

    instr_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .opcode        (opcode)
    );

    always #5 clk = ~clk;

    // Odd multiplier makes every address hold a distinct word; address 0 holds 32'h8C22_0004.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h8C22_0004;
    endfunction

    assign imem_rdata = memf(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every accepted fetch is queued, every consumed IF/ID word is popped.
    initial begin
        logic [31:0] ei, ep;
        next_addr = 32'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("req_in_reset", {31'd0, imem_req}, 32'd0);
                exp_instr.delete();
                exp_pc4.delete();
                next_addr = 32'd0;
            end else begin
                if (!if_id_valid) chk("nop_when_invalid", if_id_instr, 32'd0);
                if (exp_instr.size() >= 2) chk("req_when_full", {31'd0, imem_req}, 32'd0);
                if (imem_req) chk("fetch_addr", imem_addr, next_addr);
                if (if_id_valid && !stall && !branch_taken) begin
                    if (exp_instr.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_instr: got %h want none", if_id_instr);
                    end else begin
                        ei = exp_instr.pop_front();
                        ep = exp_pc4.pop_front();
                        chk("sb_instr", if_id_instr, ei);
                        chk("sb_pc4", if_id_pc4, ep);
                        chk("sb_opcode", {26'd0, opcode}, {26'd0, ei[31:26]});
                    end
                end
                if (branch_taken) begin
                    exp_instr.delete();
                    exp_pc4.delete();
                    next_addr = branch_target & 32'hFFFF_FFFC;
                end else if (imem_req && imem_ready) begin
                    exp_instr.push_back(memf(imem_addr));
                    exp_pc4.push_back(imem_addr + 32'd4);
                    next_addr = imem_addr + 32'd4;
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        imem_ready = 1'b1;
        repeat (3) tick();
        smp();
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'd0);
        chk("rst_pc4", if_id_pc4, 32'd0);
        tick(); reset = 1'b1;
        smp(); chk("release_c1_req", {31'd0, imem_req}, 32'd0);
        tick();
        smp(); chk("release_c2_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        tick();
        smp(); chk("lat_instr", if_id_instr, 32'h8C22_0004);
        chk("lat_opcode", {26'd0, opcode}, 32'h23);
        chk("lat_pc4", if_id_pc4, 32'd4);
        chk("lat_valid", {31'd0, if_id_valid}, 32'd1);

        // Stall for three cycles while addr 8 is fetched.
        tick(); stall = 1'b1;
        smp(); chk("s1_addr", imem_addr, 32'd8);
        chk("s1_instr", if_id_instr, memf(32'd4));
        for (int i = 0; i < 2; i++) begin
            tick();
            smp(); chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_addr", imem_addr, 32'd12);
            chk("hold_instr", if_id_instr, memf(32'd4));
            chk("hold_pc4", if_id_pc4, 32'd8);
        end
        tick(); stall = 1'b0;
        smp(); chk("drain_instr", if_id_instr, memf(32'd4));
        tick();
        smp(); chk("after_hold_instr", if_id_instr, memf(32'd8));
        chk("after_hold_pc4", if_id_pc4, 32'd12);
        chk("after_hold_addr", imem_addr, 32'd12);

        // Memory not ready for four cycles at addr 16.
        tick(); imem_ready = 1'b0;
        smp(); chk("w1_instr", if_id_instr, memf(32'd12));
        chk("w1_addr", imem_addr, 32'd16);
        for (int i = 0; i < 3; i++) begin
            tick();
            smp(); chk("wait_valid", {31'd0, if_id_valid}, 32'd0);
            chk("wait_pc4", if_id_pc4, 32'd16);
            chk("wait_addr", imem_addr, 32'd16);
        end
        tick(); imem_ready = 1'b1;
        smp(); chk("w5_addr", imem_addr, 32'd16);
        tick();
        smp(); chk("w6_instr", if_id_instr, memf(32'd16));
        chk("w6_pc4", if_id_pc4, 32'd20);

        // Branch while in HOLD with stall still high.
        tick(); stall = 1'b1;
        tick(); branch_taken = 1'b1; branch_target = 32'h0000_0043;
        smp(); chk("h2_req", {31'd0, imem_req}, 32'd0);
        tick(); branch_taken = 1'b0; stall = 1'b0;
        smp(); chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
        chk("redir_opcode", {26'd0, opcode}, 32'd0);
        chk("redir_req", {31'd0, imem_req}, 32'd0);
        tick();
        smp(); chk("target_addr", imem_addr, 32'h0000_0040);
        chk("target_req", {31'd0, imem_req}, 32'd1);

        // Redirect to the top of the address space and wrap.
        tick(); branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick(); branch_taken = 1'b0;
        smp(); chk("wrap_redir_req", {31'd0, imem_req}, 32'd0);
        tick();
        smp(); chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        smp(); chk("wrap_instr0", if_id_instr, memf(32'hFFFF_FFFC));
        chk("wrap_pc4_0", if_id_pc4, 32'd0);
        chk("wrap_addr1", imem_addr, 32'd0);
        tick();
        smp(); chk("wrap_instr1", if_id_instr, memf(32'd0));
        chk("wrap_pc4_1", if_id_pc4, 32'd4);

        // Reset in the middle of HOLD with a buffered word.
        tick(); stall = 1'b1;
        tick();
        tick(); reset = 1'b0;
        smp(); chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        tick(); reset = 1'b1; stall = 1'b0;
        smp(); chk("post_rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("post_rst_pc4", if_id_pc4, 32'd0);
        chk("post_rst_req", {31'd0, imem_req}, 32'd0);
        tick();
        smp(); chk("post_rst_addr", imem_addr, 32'd0);
        chk("post_rst_req2", {31'd0, imem_req}, 32'd1);
        tick();
        smp(); chk("post_rst_instr", if_id_instr, memf(32'd0));

        // Random traffic, checked by the scoreboard.
        for (int i = 0; i < 4000; i++) begin
            tick();
            stall = ($urandom % 4) == 0;
            imem_ready = ($urandom % 4) != 0;
            branch_taken = ($urandom % 20) == 0;
            if (($urandom % 4) == 0) branch_target = 32'hFFFF_FFF0 | ($urandom % 16);
            else branch_target = $urandom & 32'h0000_0FFF;
            reset = ($urandom % 150) != 0;
        end
        tick();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
        repeat (10) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL provide parameter NOP_INSTR, default 32'h0000_0000, the IF/ID instruction value whenever IF/ID is invalid.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  instruction-memory read request, level.
REQ-006 imem_addr  output  32  word-aligned fetch address; equals PC.
REQ-007 imem_ready  input  1  imem_rdata valid for imem_addr this cycle; ignored when imem_req=0.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 stall  input  1  hazard hold; IF/ID SHALL NOT change while high.
REQ-010 branch_taken  input  1  redirect request (branch AND zero from execute).
REQ-011 branch_target  input  32  redirect address; bits [1:0] ignored.
REQ-012 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-013 if_id_instr  output  32  IF/ID instruction word.
REQ-014 if_id_pc4  output  32  address of the IF/ID instruction plus 4.
REQ-015 opcode  output  6  if_id_instr[31:26]; feeds the decode control unit.

Function
REQ-016 The FSM SHALL have three states: FETCH (imem_req=1), HOLD (imem_req=0, skid buffer full), REDIRECT (one cycle, imem_req=0).
REQ-017 In FETCH with imem_ready=1 and stall=0, the block SHALL load IF/ID with {valid=1, imem_rdata, PC+4}, set PC<=PC+4, and stay in FETCH.
REQ-018 In FETCH with imem_ready=1 and stall=1, the block SHALL capture imem_rdata and PC+4 into a one-entry skid buffer, set PC<=PC+4, and go to HOLD.
REQ-019 In FETCH with imem_ready=0, the block SHALL hold PC and imem_addr stable, and SHALL clear if_id_valid only when stall=0.
REQ-020 In HOLD with stall=0, the block SHALL move the skid buffer into IF/ID (valid=1), empty the buffer, and return to FETCH.
REQ-021 In HOLD with stall=1, all state SHALL remain unchanged.
REQ-022 branch_taken=1 SHALL take priority over every other event in every state: PC<={branch_target[31:2],2'b00}, if_id_valid<=0, skid buffer emptied, any same-cycle imem response discarded, next state REDIRECT; stall is ignored for this flush.
REQ-023 REDIRECT SHALL last exactly one cycle and then go to FETCH; the first request to the target is issued in the cycle after REDIRECT.
REQ-024 Whenever if_id_valid=0, if_id_instr SHALL equal NOP_INSTR and if_id_pc4 SHALL be held at its last value.
REQ-025 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000; PC[1:0] SHALL always be 2'b00.
REQ-026 Best-case fetch latency: imem_rdata accepted in cycle N appears on if_id_instr and opcode in cycle N+1.
REQ-027 No instruction SHALL be lost or duplicated across any stall sequence; order out of IF/ID SHALL equal fetch order.

Reset
REQ-028 When reset=0 at a rising edge: PC<=RESET_PC, state<=REDIRECT, skid buffer empty, if_id_valid<=0, if_id_instr<=NOP_INSTR, if_id_pc4<=0; imem_req SHALL be 0 while reset=0.
REQ-029 Reset SHALL override branch_taken, stall and any in-flight response; the first imem_req=1 SHALL appear in the second cycle after reset returns to 1.

Verification
REQ-030 Reset release, imem_ready=1 always, mem[0]=32'h8C22_0004: first imem_addr 0; next cycle if_id_instr=32'h8C22_0004, opcode=6'b100011, if_id_pc4=4.
REQ-031 Stall=1 for 3 cycles with ready=1 while fetching addr 8: IF/ID frozen, imem_req=0 in HOLD, imem_addr=12; after release IF/ID shows mem[8], then mem[12], no skip or repeat.
REQ-032 branch_taken=1, branch_target=32'h0000_0043, stall=1, HOLD state: if_id_valid=0, opcode=0 next cycle, REDIRECT one cycle, next imem_addr=32'h0000_0040.
REQ-033 imem_ready=0 for 4 cycles at addr 16, stall=0: imem_addr stays 16, if_id_valid=0 from second cycle; ready=1 then loads mem[16], pc4=20.
REQ-034 Redirect to 32'hFFFF_FFFC, ready=1: fetches FFFF_FFFC then 0000_0000; if_id_pc4=0 for the first.
REQ-035 reset=0 asserted mid-HOLD with a buffered word: buffer dropped, if_id_valid=0, restart fetch at RESET_PC.
